vga_frame_checker: RTL and testbench

Synthesizable, parametrised pixel-stream self-checker for the decompressor's VGA output path. It monitors the VGA controller's pixel positions and colour outputs during one frame and compares every pixel inside a configurable view window against expected pixels supplied over a valid/ready stream. It counts per-channel mismatches, records the first failing pixel, and aborts once a mismatch limit is exceeded. It sits beside the VGA unit, on-chip or in the top-level bench.

---
 rtl/vga_frame_checker.sv | 180 ++++++++++++++++++
 tb/tb_vga_frame_checker.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_frame_checker.sv
// Pixel-stream self-checker for the VGA output path: compares in-window pixels against an expected stream.
// Define VGA_CHECKER_SIGNATURE_EN to add a CRC-16-CCITT frame signature output (frame_sig).
module vga_frame_checker #(
    parameter int PIX_W          = 8,
    parameter int NUM_CH         = 3,
    parameter int VIEW_LEFT      = 160,
    parameter int VIEW_RIGHT     = 480,
    parameter int VIEW_TOP       = 120,
    parameter int VIEW_BOTTOM    = 360,
    parameter int MAX_MISMATCHES = 10,
    parameter int CNT_W          = 20
) (
    input  logic                    Clock_50,
    input  logic                    Reset,
    input  logic                    start,
    input  logic                    VGA_vsync_n,
    input  logic                    pix_strobe,
    input  logic [9:0]              pixel_X_pos,
    input  logic [9:0]              pixel_Y_pos,
    input  logic [NUM_CH*PIX_W-1:0] pix_data,
    input  logic                    exp_valid,
    input  logic [NUM_CH*PIX_W-1:0] exp_data,
    output logic                    exp_ready,
    output logic                    busy,
    output logic                    frame_done,
    output logic                    aborted,
    output logic                    underrun,
    output logic [CNT_W-1:0]        mismatch_count,
    output logic [CNT_W-1:0]        pixel_count,
    output logic [9:0]              first_err_x,
    output logic [9:0]              first_err_y,
    output logic [NUM_CH-1:0]       first_err_mask,
`ifdef VGA_CHECKER_SIGNATURE_EN
    output logic [15:0]             frame_sig,
`endif
    output logic [2:0]              dbg_state
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WAIT_VS = 3'd1,
        SYNC    = 3'd2,
        CHECK   = 3'd3,
        DONE    = 3'd4,
        ABORT   = 3'd5
    } state_t;

    localparam logic [9:0]       LEFT_L   = 10'(VIEW_LEFT);
    localparam logic [9:0]       RIGHT_L  = 10'(VIEW_RIGHT);
    localparam logic [9:0]       TOP_L    = 10'(VIEW_TOP);
    localparam logic [9:0]       BOTTOM_L = 10'(VIEW_BOTTOM);
    localparam logic [CNT_W-1:0] MAX_L    = CNT_W'(MAX_MISMATCHES);

    state_t            state, state_n;
    logic              vsync_q;
    logic [9:0]        col_q, row_q;
    logic              vs_fall, strobe_en, in_window, hit, consume, over_limit;
    logic [NUM_CH-1:0] diff;
    logic [CNT_W:0]    pop, mm_sum;
    logic [CNT_W-1:0]  mm_next;

    // A strobe tests the position latched on the previous strobe; a falling vsync edge ends the frame
    // and suppresses any strobe in the same cycle.
    assign vs_fall   = vsync_q & ~VGA_vsync_n;
    assign strobe_en = (state == CHECK) && pix_strobe && !vs_fall;
    assign in_window = (row_q >= TOP_L) && (row_q < BOTTOM_L) &&
                       (col_q >= LEFT_L) && (col_q < RIGHT_L);
    assign hit       = strobe_en && in_window;

    // Handshake: exp_data is consumed in exactly the cycle where exp_valid && exp_ready; exp_ready is a
    // single-cycle pulse raised only for an in-window strobe with exp_valid already high (never waits).
    assign consume   = hit && exp_valid;
    assign exp_ready = consume;

    assign busy       = (state != IDLE);
    assign frame_done = (state == DONE);
    assign dbg_state  = state;

    always_comb begin
        diff = '0;
        pop  = '0;
        for (int ch = 0; ch < NUM_CH; ch++) begin
            diff[ch] = (pix_data[ch*PIX_W +: PIX_W] != exp_data[ch*PIX_W +: PIX_W]);
            pop      = pop + {{CNT_W{1'b0}}, diff[ch]};
        end
        mm_sum     = {1'b0, mismatch_count} + pop;
        mm_next    = mm_sum[CNT_W] ? {CNT_W{1'b1}} : mm_sum[CNT_W-1:0];
        over_limit = (mm_next > MAX_L);
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = WAIT_VS;
            WAIT_VS: if (!VGA_vsync_n) state_n = SYNC;
            SYNC:    if (VGA_vsync_n) state_n = CHECK;
            CHECK: begin
                if (vs_fall)                   state_n = DONE;
                else if (hit && !exp_valid)    state_n = ABORT;
                else if (consume && over_limit) state_n = ABORT;
            end
            DONE:    state_n = IDLE;
            ABORT:   state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

`ifdef VGA_CHECKER_SIGNATURE_EN
    // Bit-serial CRC-16-CCITT over the whole pixel word, MSB (channel NUM_CH-1) first.
    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [NUM_CH*PIX_W-1:0] d);
        logic [15:0] r;
        logic        fb;
        r = c;
        for (int i = NUM_CH*PIX_W-1; i >= 0; i--) begin
            fb = r[15] ^ d[i];
            r  = {r[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
        end
        return r;
    endfunction
`endif

    always_ff @(posedge Clock_50) begin
        if (Reset) begin
            state          <= IDLE;
            vsync_q        <= 1'b0;
            col_q          <= '0;
            row_q          <= '0;
            aborted        <= 1'b0;
            underrun       <= 1'b0;
            mismatch_count <= '0;
            pixel_count    <= '0;
            first_err_x    <= '0;
            first_err_y    <= '0;
            first_err_mask <= '0;
`ifdef VGA_CHECKER_SIGNATURE_EN
            frame_sig      <= '0;
`endif
        end else begin
            state   <= state_n;
            vsync_q <= VGA_vsync_n;
            if (state == IDLE && start) begin
                col_q          <= '0;
                row_q          <= '0;
                aborted        <= 1'b0;
                underrun       <= 1'b0;
                mismatch_count <= '0;
                pixel_count    <= '0;
                first_err_x    <= '0;
                first_err_y    <= '0;
                first_err_mask <= '0;
`ifdef VGA_CHECKER_SIGNATURE_EN
                frame_sig      <= 16'hFFFF;
`endif
            end
            if (strobe_en) begin
                col_q <= pixel_X_pos;
                row_q <= pixel_Y_pos;
            end
            if (consume) begin
                mismatch_count <= mm_next;
                pixel_count    <= pixel_count + 1'b1;
                // A zero captured mask means no mismatch has been recorded yet this frame.
                if (|diff && first_err_mask == '0) begin
                    first_err_x    <= col_q;
                    first_err_y    <= row_q;
                    first_err_mask <= diff;
                end
                if (over_limit) aborted <= 1'b1;
`ifdef VGA_CHECKER_SIGNATURE_EN
                frame_sig <= crc_step(frame_sig, pix_data);
`endif
            end
            if (hit && !exp_valid) begin
                underrun <= 1'b1;
                aborted  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vga_frame_checker.sv
// Directed, table-driven bench for vga_frame_checker using a reduced view window to keep frames short.
module tb_vga_frame_checker;

    localparam int L = 190, R = 230, T = 140, B = 170, MAXM = 10, CW = 20;
    localparam int WIN_W = R - L, WIN_PIX = (R - L) * (B - T);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, start, vs_n, strobe, ev;
    logic [9:0]    px, py;
    logic [23:0]   pix, expd;
    logic          exp_ready, busy, frame_done, aborted, underrun;
    logic [CW-1:0] mismatch_count, pixel_count;
    logic [9:0]    first_err_x, first_err_y;
    logic [2:0]    first_err_mask, dbg_state;
`ifdef VGA_CHECKER_SIGNATURE_EN
    logic [15:0]   frame_sig;
`endif

    vga_frame_checker #(
        .PIX_W(8), .NUM_CH(3), .VIEW_LEFT(L), .VIEW_RIGHT(R), .VIEW_TOP(T), .VIEW_BOTTOM(B),
        .MAX_MISMATCHES(MAXM), .CNT_W(CW)
    ) dut (
        .Clock_50(clk), .Reset(rst), .start(start), .VGA_vsync_n(vs_n), .pix_strobe(strobe),
        .pixel_X_pos(px), .pixel_Y_pos(py), .pix_data(pix), .exp_valid(ev), .exp_data(expd),
        .exp_ready(exp_ready), .busy(busy), .frame_done(frame_done), .aborted(aborted),
        .underrun(underrun), .mismatch_count(mismatch_count), .pixel_count(pixel_count),
        .first_err_x(first_err_x), .first_err_y(first_err_y), .first_err_mask(first_err_mask),
`ifdef VGA_CHECKER_SIGNATURE_EN
        .frame_sig(frame_sig),
`endif
        .dbg_state(dbg_state)
    );

    int tests = 0, fails = 0;
    int ready_cnt = 0, done_cnt = 0, viol = 0;
    logic prev_ready = 1'b0;

    // Protocol monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (exp_ready) begin
            ready_cnt++;
            if (!exp_valid_q() || prev_ready || !busy) viol++;
        end
        if (frame_done) done_cnt++;
        prev_ready = exp_ready;
    end

    function automatic logic exp_valid_q();
        return ev;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [23:0] golden(input int x, input int y);
        logic [7:0] xb, yb;
        xb = x[7:0];
        yb = y[7:0];
        return {xb + yb, xb ^ 8'h5A, yb + 8'd17};
    endfunction

    function automatic bit inwin(input int x, input int y);
        return (x >= L) && (x < R) && (y >= T) && (y < B);
    endfunction

    task automatic drive_strobe(input int x, input int y, input logic [23:0] p, input logic [23:0] e,
                                input logic v, input logic st);
        strobe = 1'b1; px = 10'(x); py = 10'(y); pix = p; expd = e; ev = v; start = st;
        step();
        strobe = 1'b0; start = 1'b0;
        step();
    endtask

    task automatic vsync_pulse();
        vs_n = 1'b0;
        repeat (4) step();
        vs_n = 1'b1;
        repeat (2) step();
    endtask

    typedef struct {
        int         bad_start;
        int         bad_n;
        logic [2:0] bad_mask;
        int         drop_at;
        bit         mid_start;
        bit         pre_junk;
        int         e_done;
        int         e_ab;
        int         e_ur;
        int         e_mm;
        int         e_pix;
        int         e_fx;
        int         e_fy;
        logic [2:0] e_mask;
    } scen_t;

    function automatic scen_t mk(input int bs, input int bn, input logic [2:0] bm, input int drop,
                                 input bit ms, input bit pj, input int ed, input int eab, input int eur,
                                 input int emm, input int epix, input int efx, input int efy,
                                 input logic [2:0] emask);
        scen_t s;
        s.bad_start = bs; s.bad_n = bn; s.bad_mask = bm; s.drop_at = drop;
        s.mid_start = ms; s.pre_junk = pj;
        s.e_done = ed; s.e_ab = eab; s.e_ur = eur; s.e_mm = emm; s.e_pix = epix;
        s.e_fx = efx; s.e_fy = efy; s.e_mask = emask;
        return s;
    endfunction

    task automatic run_scen(input scen_t s);
        int          widx, prev_x, prev_y, r0, d0, v0, wait_n;
        bit          dropped, mid_done, iw;
        logic [23:0] g, p;
        logic        st;
        r0 = ready_cnt; d0 = done_cnt; v0 = viol;
        widx = 0; prev_x = 0; prev_y = 0; dropped = 0; mid_done = 0;
        start = 1'b1; step(); start = 1'b0; step();
        if (s.pre_junk) begin
            for (int i = 0; i < 50; i++) drive_strobe(L + i % WIN_W, T + 1, 24'hFFFFFF, 24'h0, 1'b1, 1'b0);
            check("junk_busy", busy, 1);
            check("junk_state", dbg_state, 1);
            check("junk_pixels", pixel_count, 0);
            check("junk_ready", ready_cnt - r0, 0);
        end
        vsync_pulse();
        for (int y = T - 1; y <= B; y++) begin
            for (int x = L - 2; x <= R; x++) begin
                iw = inwin(prev_x, prev_y);
                g = golden(prev_x, prev_y);
                p = g;
                st = 1'b0;
                if (iw) begin
                    if (widx >= s.bad_start && widx < s.bad_start + s.bad_n) begin
                        for (int ch = 0; ch < 3; ch++) if (s.bad_mask[ch]) p[ch*8] = ~p[ch*8];
                    end
                    if (s.drop_at >= 0 && widx == s.drop_at) dropped = 1;
                    if (s.mid_start && widx == 600 && !mid_done) begin
                        st = 1'b1;
                        mid_done = 1;
                    end
                    widx++;
                end
                drive_strobe(x, y, p, g, !dropped, st);
                prev_x = x; prev_y = y;
            end
        end
        vs_n = 1'b0;
        step();
        wait_n = 0;
        while (busy && wait_n < 20) begin
            step();
            wait_n++;
        end
        check("idle_timeout", busy, 0);
        vs_n = 1'b1; ev = 1'b1;
        step();
        check("frame_done_pulses", done_cnt - d0, s.e_done);
        check("aborted", aborted, s.e_ab);
        check("underrun", underrun, s.e_ur);
        check("mismatch_count", mismatch_count, s.e_mm);
        check("pixel_count", pixel_count, s.e_pix);
        check("first_err_x", first_err_x, s.e_fx);
        check("first_err_y", first_err_y, s.e_fy);
        check("first_err_mask", first_err_mask, s.e_mask);
        check("ready_pulses", ready_cnt - r0, s.e_pix);
        check("handshake_viol", viol - v0, 0);
    endtask

    scen_t scen[9];
    int    r0, d0;

    initial begin
        // Window index of (200,150) is (150-140)*40 + (200-190) = 410; last window index is 1199 at (229,169).
        scen[0] = mk(0,   0,  3'b000, -1,  0, 0, 1, 0, 0, 0,  WIN_PIX, 0,   0,   3'b000);
        scen[1] = mk(410, 1,  3'b010, -1,  0, 0, 1, 0, 0, 1,  WIN_PIX, 200, 150, 3'b010);
        scen[2] = mk(410, 11, 3'b001, -1,  0, 0, 0, 1, 0, 11, 421,     200, 150, 3'b001);
        scen[3] = mk(410, 10, 3'b001, -1,  0, 0, 1, 0, 0, 10, WIN_PIX, 200, 150, 3'b001);
        scen[4] = mk(0,   4,  3'b111, -1,  0, 0, 0, 1, 0, 12, 4,       190, 140, 3'b111);
        scen[5] = mk(0,   0,  3'b000, 999, 0, 0, 0, 1, 1, 0,  999,     0,   0,   3'b000);
        scen[6] = mk(0,   1,  3'b100, -1,  1, 0, 1, 0, 0, 1,  WIN_PIX, 190, 140, 3'b100);
        scen[7] = mk(1199, 1, 3'b100, -1,  0, 0, 1, 0, 0, 1,  WIN_PIX, 229, 169, 3'b100);
        scen[8] = mk(0,   0,  3'b000, -1,  0, 1, 1, 0, 0, 0,  WIN_PIX, 0,   0,   3'b000);

        rst = 1'b1; start = 1'b0; vs_n = 1'b1; strobe = 1'b0; ev = 1'b1;
        px = '0; py = '0; pix = '0; expd = '0;
        repeat (3) step();
        check("rst_busy", busy, 0);
        check("rst_state", dbg_state, 0);
        check("rst_flags", {exp_ready, frame_done, aborted, underrun}, 0);
        check("rst_counts", mismatch_count | pixel_count, 0);
        check("rst_first_err", {first_err_x, first_err_y, first_err_mask}, 0);
        rst = 1'b0;
        step();

        for (int i = 0; i < 9; i++) run_scen(scen[i]);

        // Falling vsync in the same cycle as a strobe ends the frame and ignores the strobe.
        r0 = ready_cnt; d0 = done_cnt;
        start = 1'b1; step(); start = 1'b0; step();
        vsync_pulse();
        drive_strobe(190, 140, golden(0, 0), golden(0, 0), 1'b1, 1'b0);
        drive_strobe(191, 140, golden(190, 140), golden(190, 140), 1'b1, 1'b0);
        vs_n = 1'b0;
        drive_strobe(192, 140, golden(191, 140), golden(191, 140), 1'b1, 1'b0);
        step();
        check("vs_wins_pixels", pixel_count, 1);
        check("vs_wins_ready", ready_cnt - r0, 1);
        check("vs_wins_done", done_cnt - d0, 1);
        vs_n = 1'b1;
        step();

        // Reset in the middle of CHECK.
        start = 1'b1; step(); start = 1'b0; step();
        vsync_pulse();
        for (int x = L; x < R; x++) drive_strobe(x, T, golden(x, T), golden(x, T), 1'b1, 1'b0);
        check("pre_reset_pixels", pixel_count, WIN_W - 1);
        check("pre_reset_state", dbg_state, 3);
        rst = 1'b1;
        step();
        check("mid_reset_busy", busy, 0);
        check("mid_reset_counts", mismatch_count | pixel_count, 0);
        check("mid_reset_flags", {exp_ready, frame_done, aborted, underrun}, 0);
        rst = 1'b0;
        step();

`ifdef VGA_CHECKER_SIGNATURE_EN
        begin
            logic [15:0] sig_a, sig_b, sig_c;
            run_scen(scen[0]);
            sig_a = frame_sig;
            run_scen(scen[0]);
            sig_b = frame_sig;
            run_scen(scen[1]);
            sig_c = frame_sig;
            check("sig_repeat", sig_b, sig_a);
            check("sig_flip_differs", 32'(sig_c != sig_a), 1);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
